// File: rtl/gray_packer_if.sv
// Sample/word handshake bundle for gray_packer: sample stream in, packed 32-bit words out.
// slave = the packer itself, master = the environment feeding samples and consuming words.
interface gray_packer_if;
  logic        sync;
  logic [7:0]  in_gray;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_eol;
  logic        out_eof;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  sync, in_gray, in_valid, out_ready,
    output in_ready, out_data, out_keep, out_eol, out_eof, out_valid
  );

  modport master (
    output sync, in_gray, in_valid, out_ready,
    input  in_ready, out_data, out_keep, out_eol, out_eof, out_valid
  );
endinterface

// File: rtl/gray_packer.sv
// Packs 8-bit gray samples four to a 32-bit word with line/frame tracking and zero padding at line end.
// Optional macro GRAY_PACK_THRESH_EN binarizes each sample against THRESH before packing.
module gray_packer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int THRESH     = 128
) (
  input  logic           clk,
  input  logic           rst,
  gray_packer_if.slave   bus
);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0]    idx;
  logic [23:0]   asm_q;

  logic          accept;
  logic [7:0]    sample;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic [1:0]    cur_idx;
  logic [23:0]   cur_asm;
  logic          last_col;
  logic          last_row;
  logic          complete;
  logic [31:0]   word;
  logic [3:0]    keep;

  assign bus.in_ready = ~(bus.out_valid & ~bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

`ifdef GRAY_PACK_THRESH_EN
  assign sample = (int'({24'd0, bus.in_gray}) >= THRESH) ? 8'hFF : 8'h00;
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
  assign sample = bus.in_gray;
`endif

  // A sync in the same cycle as an accept places that sample at the start of a fresh frame.
  assign cur_col  = bus.sync ? '0 : col;
  assign cur_row  = bus.sync ? '0 : row;
  assign cur_idx  = bus.sync ? '0 : idx;
  assign cur_asm  = bus.sync ? '0 : asm_q;
  assign last_col = (cur_col == LAST_COL);
  assign last_row = (cur_row == LAST_ROW);
  assign complete = accept & ((cur_idx == 2'd3) | last_col);

  // Assembly is cleared at every word start, so bytes above cur_idx are already zero padding.
  always_comb begin
    word = {8'h00, cur_asm};
    word[{cur_idx, 3'b000} +: 8] = sample;
    keep = 4'b1111 >> (2'd3 - cur_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col           <= '0;
      row           <= '0;
      idx           <= '0;
      asm_q         <= '0;
      bus.out_data  <= '0;
      bus.out_keep  <= '0;
      bus.out_eol   <= 1'b0;
      bus.out_eof   <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      if (bus.out_valid & bus.out_ready)
        bus.out_valid <= 1'b0;

      if (complete) begin
        bus.out_data  <= word;
        bus.out_keep  <= keep;
        bus.out_eol   <= last_col;
        bus.out_eof   <= last_col & last_row;
        bus.out_valid <= 1'b1;
      end

      if (accept) begin
        if (complete) begin
          idx   <= '0;
          asm_q <= '0;
        end else begin
          idx   <= cur_idx + 2'd1;
          asm_q <= word[23:0];
        end
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end else if (bus.sync) begin
        col   <= '0;
        row   <= '0;
        idx   <= '0;
        asm_q <= '0;
      end
    end
  end
endmodule

// File: tb/tb_gray_packer.sv
// Self-checking bench for gray_packer: directed scenarios plus random traffic against a sample-list model.
module tb_gray_packer;
  localparam int W  = 6;
  localparam int H  = 2;
  localparam int TH = 128;

  logic clk;
  logic rst;
  gray_packer_if bus();

  gray_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .THRESH(TH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: samples since frame start and the bytes of the word being built.
  int          pos;
  logic [7:0]  pend[$];
  logic        m_ov;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_eol;
  logic        m_eof;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] xform(input logic [7:0] d);
`ifdef GRAY_PACK_THRESH_EN
    return (int'(d) >= TH) ? 8'hFF : 8'h00;
`else
    return d;
`endif
  endfunction

  task automatic model_reset();
    pos = 0;
    pend.delete();
    m_ov = 0; m_data = '0; m_keep = '0; m_eol = 0; m_eof = 0;
  endtask

  // One clock: drive at negedge, check the registered state, then advance the model past the posedge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic s, input logic ordy);
    logic exp_ir, acc, done;
    int c, r;
    logic [31:0] wd;
    @(negedge clk);
    bus.in_valid = v; bus.in_gray = d; bus.sync = s; bus.out_ready = ordy;
    #1;
    exp_ir = ~(m_ov & ~ordy);
    check_eq("in_ready", bus.in_ready, exp_ir);
    check_eq("out_valid", bus.out_valid, m_ov);
    if (m_ov) begin
      check_eq("out_data", bus.out_data, m_data);
      check_eq("out_keep", bus.out_keep, m_keep);
      check_eq("out_eol", bus.out_eol, m_eol);
      check_eq("out_eof", bus.out_eof, m_eof);
    end
    acc  = v & exp_ir;
    done = 0;
    if (s) begin
      pos = 0;
      pend.delete();
    end
    if (m_ov && ordy) m_ov = 0;
    if (acc) begin
      c = pos % W;
      r = (pos / W) % H;
      pend.push_back(xform(d));
      if (pend.size() == 4 || c == W - 1) begin
        wd = '0;
        for (int i = 0; i < pend.size(); i++) wd[i*8 +: 8] = pend[i];
        m_data = wd;
        m_keep = 4'((1 << pend.size()) - 1);
        m_eol  = (c == W - 1);
        m_eof  = (c == W - 1) && (r == H - 1);
        m_ov   = 1;
        pend.delete();
      end
      pos = (pos + 1) % (W * H);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    bus.in_valid = 0; bus.sync = 0;
    #2 rst = 1;
    #1;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_data", bus.out_data, 0);
    check_eq("rst_out_keep", bus.out_keep, 0);
    check_eq("rst_out_eol", bus.out_eol, 0);
    check_eq("rst_out_eof", bus.out_eof, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1;
    bus.in_valid = 0; bus.in_gray = '0; bus.sync = 0; bus.out_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    check_eq("reset_out_valid", bus.out_valid, 0);
    check_eq("reset_in_ready", bus.in_ready, 1);
    check_eq("reset_out_data", bus.out_data, 0);

    // Two full lines: padded line ends, eof on the last word.
    for (int i = 0; i < 12; i++) cycle(1, 8'h10 + 8'(i), 0, 1);
    repeat (2) cycle(0, 8'h00, 0, 1);

    // Backpressure: stall with a word held, then release.
    for (int i = 0; i < 4; i++) cycle(1, 8'h40 + 8'(i), 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 8'h50 + 8'(i), 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 8'h60 + 8'(i), 0, 1);
    repeat (2) cycle(0, 8'h00, 0, 1);

    // Sync discards a partial word; sync with a sample starts the new frame.
    cycle(1, 8'hAA, 0, 1);
    cycle(1, 8'hBB, 0, 1);
    cycle(1, 8'hCC, 1, 1);
    for (int i = 0; i < 8; i++) cycle(1, 8'hD0 + 8'(i), 0, 1);
    cycle(0, 8'h00, 1, 1);
    for (int i = 0; i < 6; i++) cycle(1, 8'hE0 + 8'(i), 0, 1);
    repeat (2) cycle(0, 8'h00, 0, 1);

    // Reset mid-word, then mid-stall.
    cycle(1, 8'h71, 0, 1);
    cycle(1, 8'h72, 0, 1);
    async_reset();
    for (int i = 0; i < 4; i++) cycle(1, 8'h80 + 8'(i), 0, 1);
    cycle(1, 8'h90, 0, 0);
    cycle(1, 8'h91, 0, 0);
    async_reset();
    for (int i = 0; i < 6; i++) cycle(1, 8'hA0 + 8'(i), 0, 1);
    repeat (2) cycle(0, 8'h00, 0, 1);

    // Random traffic with occasional syncs.
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 64) == 0, ($urandom % 10) < 7);
    repeat (3) cycle(0, 8'h00, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
